// File: rtl/sad_pkg.sv
// Shared constants, comparator state type and arithmetic helpers for the SAD array.
// Helpers work on FN_W-bit operands, so PIX_W and ACC_W must not exceed FN_W.
package sad_pkg;

    localparam int PIX_W_DEF      = 8;
    localparam int ACC_W_DEF      = 16;
    localparam int NUM_PE_DEF     = 16;
    localparam int BLK_PIXELS_DEF = 256;
    localparam int FN_W           = 32;

    typedef enum logic {
        CMP_IDLE,
        CMP_COLLECT
    } cmp_state_e;

    // Larger minus smaller keeps the result unsigned without a sign bit.
    function automatic logic [FN_W-1:0] abs_diff(input logic [FN_W-1:0] a,
                                                 input logic [FN_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [FN_W-1:0] sat_add(input logic [FN_W-1:0] acc,
                                                input logic [FN_W-1:0] d,
                                                input logic [FN_W-1:0] max);
        logic [FN_W:0] sum;
        sum = {1'b0, acc} + {1'b0, d};
        return (sum > {1'b0, max}) ? max : sum[FN_W-1:0];
    endfunction

endpackage

// File: rtl/sad_pe.sv
// One SAD element: one-cycle delay stage for r and the pixel tags, the s1/s2
// select and a saturating accumulator that pulses done after a block's last pixel.
module sad_pe
    import sad_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             vld_i,
    input  logic             start_i,
    input  logic             last_i,
    input  logic [PIX_W-1:0] r_i,
    input  logic [PIX_W-1:0] s1_i,
    input  logic [PIX_W-1:0] s2_i,
    input  logic             sel_i,
    output logic             vld_o,
    output logic             start_o,
    output logic             last_o,
    output logic [PIX_W-1:0] r_o,
    output logic [ACC_W-1:0] acc_o,
    output logic             done_o
);

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic [PIX_W-1:0] r_q;
    logic             vld_q, start_q, last_q, done_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [PIX_W-1:0] s_mux, d;

    assign s_mux = sel_i ? s1_i : s2_i;
    assign d     = PIX_W'(abs_diff(FN_W'(r_i), FN_W'(s_mux)));

    always_comb begin
        acc_d = acc_q;
        if (vld_i) begin
            if (start_i) acc_d = ACC_W'(d);
            else         acc_d = ACC_W'(sat_add(FN_W'(acc_q), FN_W'(d), FN_W'(ACC_MAX)));
        end
    end

    // r ripples every cycle; untagged cycles travel as bubbles with vld low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q     <= '0;
            vld_q   <= 1'b0;
            start_q <= 1'b0;
            last_q  <= 1'b0;
            acc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            r_q     <= r_i;
            vld_q   <= vld_i;
            start_q <= vld_i & start_i;
            last_q  <= vld_i & last_i;
            acc_q   <= acc_d;
            done_q  <= vld_i & last_i;
        end
    end

    assign vld_o   = vld_q;
    assign start_o = start_q;
    assign last_o  = last_q;
    assign r_o     = r_q;
    assign acc_o   = acc_q;
    assign done_o  = done_q;

endmodule

// File: rtl/sad_pe_array.sv
// Systolic SAD array: block pixel counter, NUM_PE chained elements and a
// sequential min-comparator that reports the best candidate once per block.
module sad_pe_array
    import sad_pkg::*;
#(
    parameter int PIX_W      = PIX_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int NUM_PE     = NUM_PE_DEF,
    parameter int BLK_PIXELS = BLK_PIXELS_DEF,
    parameter int IDX_W      = $clog2(NUM_PE)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              start,
    input  logic [PIX_W-1:0]  r,
    input  logic [PIX_W-1:0]  s1,
    input  logic [PIX_W-1:0]  s2,
    input  logic [NUM_PE-1:0] s_sel,
    output logic [PIX_W-1:0]  rpipe_out,
    output logic              busy,
    output logic              result_valid,
    output logic [ACC_W-1:0]  best_sad,
    output logic [IDX_W-1:0]  best_idx
);

    localparam int CNT_W = $clog2(BLK_PIXELS + 1);
    localparam int INF_W = IDX_W + 2;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             open_q, open_d;
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic             busy_q;
    logic             tag_vld, tag_start, tag_last;
    logic             result_fire;

    always_comb begin
        tag_vld   = in_valid && (start || open_q);
        tag_start = in_valid && start;
        tag_last  = 1'b0;
        cnt_d     = cnt_q;
        open_d    = open_q;
        if (in_valid && start) begin
            tag_last = (BLK_PIXELS == 1);
            open_d   = (BLK_PIXELS != 1);
            cnt_d    = open_d ? CNT_W'(1) : '0;
        end else if (in_valid && open_q) begin
            if (cnt_q == CNT_W'(BLK_PIXELS - 1)) begin
                tag_last = 1'b1;
                open_d   = 1'b0;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Blocks closed but not yet reported keep busy high behind the counter.
    always_comb begin
        inflight_d = inflight_q;
        case ({tag_last, result_fire})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            open_q     <= 1'b0;
            inflight_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            open_q     <= open_d;
            inflight_q <= inflight_d;
            busy_q     <= open_d || (inflight_d != '0);
        end
    end

    logic [NUM_PE:0][PIX_W-1:0]  r_ch;
    logic [NUM_PE:0]             vld_ch, st_ch, last_ch;
    logic [NUM_PE-1:0][ACC_W-1:0] acc;
    logic [NUM_PE-1:0]           done;
    logic                        unused_tail;

    assign r_ch[0]    = r;
    assign vld_ch[0]  = tag_vld;
    assign st_ch[0]   = tag_start;
    assign last_ch[0] = tag_last;

    for (genvar g = 0; g < NUM_PE; g++) begin : g_pe
        sad_pe #(
            .PIX_W (PIX_W),
            .ACC_W (ACC_W)
        ) u_pe (
            .clock   (clock),
            .reset_n (reset_n),
            .vld_i   (vld_ch[g]),
            .start_i (st_ch[g]),
            .last_i  (last_ch[g]),
            .r_i     (r_ch[g]),
            .s1_i    (s1),
            .s2_i    (s2),
            .sel_i   (s_sel[g]),
            .vld_o   (vld_ch[g+1]),
            .start_o (st_ch[g+1]),
            .last_o  (last_ch[g+1]),
            .r_o     (r_ch[g+1]),
            .acc_o   (acc[g]),
            .done_o  (done[g])
        );
    end

    assign unused_tail = ^{vld_ch[NUM_PE], st_ch[NUM_PE], last_ch[NUM_PE]};
    assign rpipe_out   = r_ch[NUM_PE];

    cmp_state_e       state_q;
    logic [ACC_W-1:0] run_sad_q, cand_sad, best_sad_q;
    logic [IDX_W-1:0] run_idx_q, cand_idx, best_idx_q;
    logic             result_valid_q;

    // Upward scan with strict compare keeps the lower index on ties.
    always_comb begin
        cand_sad = run_sad_q;
        cand_idx = run_idx_q;
        for (int i = 1; i < NUM_PE; i++) begin
            if (done[i] && (acc[i] < cand_sad)) begin
                cand_sad = acc[i];
                cand_idx = IDX_W'(i);
            end
        end
    end

    assign result_fire = (state_q == CMP_COLLECT) && done[NUM_PE-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= CMP_IDLE;
            run_sad_q      <= '0;
            run_idx_q      <= '0;
            best_sad_q     <= '0;
            best_idx_q     <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                CMP_IDLE: begin
                    if (done[0]) begin
                        state_q   <= CMP_COLLECT;
                        run_sad_q <= acc[0];
                        run_idx_q <= '0;
                    end
                end
                CMP_COLLECT: begin
                    if (done[NUM_PE-1]) begin
                        best_sad_q     <= cand_sad;
                        best_idx_q     <= cand_idx;
                        result_valid_q <= 1'b1;
                        if (done[0]) begin
                            run_sad_q <= acc[0];
                            run_idx_q <= '0;
                        end else begin
                            state_q <= CMP_IDLE;
                        end
                    end else begin
                        run_sad_q <= cand_sad;
                        run_idx_q <= cand_idx;
                    end
                end
                default: state_q <= CMP_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign best_sad     = best_sad_q;
    assign best_idx     = best_idx_q;

endmodule

// File: tb/tb_sad_pe_array.sv
// Directed + randomized bench for sad_pe_array; a per-cycle log of the inputs
// feeds a displacement-sum reference model that predicts every result pulse.
module tb_sad_pe_array;
    localparam int PIX_W = 8;
    localparam int ACC_W = 10;
    localparam int NP    = 4;
    localparam int BLK   = 4;
    localparam int IDX_W = 2;
    localparam int MAXC  = 4096;
    localparam int SAT_BLK = 256;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0, start = 1'b0;
    logic [PIX_W-1:0] r = '0, s1 = '0, s2 = '0;
    logic [NP-1:0] s_sel = '0;
    logic [PIX_W-1:0] rpipe_out;
    logic busy, result_valid;
    logic [ACC_W-1:0] best_sad;
    logic [IDX_W-1:0] best_idx;

    logic b_in_valid = 1'b0, b_start = 1'b0;
    logic [7:0] b_r = '0, b_s1 = '0, b_s2 = '0;
    logic [NP-1:0] b_sel = '0;
    logic [7:0] b_rpipe;
    logic b_busy, b_rv;
    logic [7:0] b_sad;
    logic [IDX_W-1:0] b_idx;

    sad_pe_array #(.PIX_W(PIX_W), .ACC_W(ACC_W), .NUM_PE(NP), .BLK_PIXELS(BLK), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .start(start),
        .r(r), .s1(s1), .s2(s2), .s_sel(s_sel), .rpipe_out(rpipe_out), .busy(busy),
        .result_valid(result_valid), .best_sad(best_sad), .best_idx(best_idx));

    sad_pe_array #(.PIX_W(8), .ACC_W(8), .NUM_PE(NP), .BLK_PIXELS(SAT_BLK), .IDX_W(IDX_W)) dut_sat (
        .clock(clock), .reset_n(reset_n), .in_valid(b_in_valid), .start(b_start),
        .r(b_r), .s1(b_s1), .s2(b_s2), .s_sel(b_sel), .rpipe_out(b_rpipe), .busy(b_busy),
        .result_valid(b_rv), .best_sad(b_sad), .best_idx(b_idx));

    always #5 clock = ~clock;

    int tests = 0, fails = 0;
    int cyc = 0, rst_cyc = 0;
    int r_log[MAXC], s1_log[MAXC], s2_log[MAXC];
    logic [NP-1:0] sel_log[MAXC];
    int cur_pix[$], done_pix[$], pend_end[$];
    bit m_open = 0;
    int got_cyc[$], got_sad[$], got_idx[$];
    int b_cnt = 0, b_got_sad = 0, b_got_idx = 0, b_got_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input bit st, input int rv, input int a, input int b,
                        input logic [NP-1:0] sel);
        in_valid = v; start = st; r = rv[7:0]; s1 = a[7:0]; s2 = b[7:0]; s_sel = sel;
        r_log[cyc] = rv & 255; s1_log[cyc] = a & 255; s2_log[cyc] = b & 255; sel_log[cyc] = sel;
        if (v && st) begin
            cur_pix.delete(); cur_pix.push_back(cyc); m_open = 1;
        end else if (v && m_open) begin
            cur_pix.push_back(cyc);
        end
        if (m_open && cur_pix.size() == BLK) begin
            foreach (cur_pix[k]) done_pix.push_back(cur_pix[k]);
            pend_end.push_back(cyc + NP);
            cur_pix.delete(); m_open = 0;
        end
        @(posedge clock); #1;
        if (result_valid) begin
            got_cyc.push_back(cyc); got_sad.push_back(int'(best_sad)); got_idx.push_back(int'(best_idx));
        end
        if (b_rv) begin
            b_cnt++; b_got_sad = int'(b_sad); b_got_idx = int'(b_idx); b_got_cyc = cyc;
        end
        while (pend_end.size() > 0 && pend_end[0] <= cyc) void'(pend_end.pop_front());
        check("busy", busy, (m_open || pend_end.size() > 0) ? 1 : 0);
        if (cyc - rst_cyc > NP) check("rpipe_out", rpipe_out, r_log[cyc-NP+1]);
        cyc++;
    endtask

    task automatic rnd_step(input bit v, input bit st);
        step(v, st, $urandom_range(255), $urandom_range(255), $urandom_range(255), NP'($urandom));
    endtask

    task automatic idle_rnd(input int n);
        for (int k = 0; k < n; k++) rnd_step(0, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; in_valid = 0; start = 0;
        r_log[cyc] = 0; s1_log[cyc] = 0; s2_log[cyc] = 0; sel_log[cyc] = '0;
        cur_pix.delete(); pend_end.delete(); m_open = 0;
        @(posedge clock); #1;
        check("rst_result_valid", result_valid, 0);
        check("rst_best_sad", best_sad, 0);
        check("rst_best_idx", best_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_rpipe_out", rpipe_out, 0);
        rst_cyc = cyc; cyc++;
        reset_n = 1'b1;
    endtask

    // Element i pairs the r of each block pixel with the search pixel driven i cycles later.
    task automatic verify(input string tag);
        int nb, base, lastc, t, rv, sv, sum, bs, bi;
        nb = done_pix.size() / BLK;
        check({tag, "_count"}, got_cyc.size(), nb);
        for (int b = 0; b < nb; b++) begin
            base = b * BLK; lastc = done_pix[base+BLK-1];
            bs = -1; bi = 0;
            for (int i = 0; i < NP; i++) begin
                sum = 0;
                for (int k = 0; k < BLK; k++) begin
                    t = done_pix[base+k] + i;
                    rv = r_log[done_pix[base+k]];
                    sv = sel_log[t][i] ? s1_log[t] : s2_log[t];
                    sum += (rv > sv) ? rv - sv : sv - rv;
                end
                if (sum > (1 << ACC_W) - 1) sum = (1 << ACC_W) - 1;
                if (bs < 0 || sum < bs) begin bs = sum; bi = i; end
            end
            if (b < got_cyc.size()) begin
                check({tag, "_cycle"}, got_cyc[b], lastc + NP);
                check({tag, "_sad"}, got_sad[b], bs);
                check({tag, "_idx"}, got_idx[b], bi);
            end
        end
        done_pix.delete(); got_cyc.delete(); got_sad.delete(); got_idx.delete();
    endtask

    int lastc;

    initial begin
        do_reset();
        idle_rnd(NP + 1);

        // Select mux: constant pixels, s_sel = 0101 -> elements 1/3 give 8.
        for (int k = 0; k < BLK; k++) step(1, k == 0, 10, 20, 12, 4'b0101);
        lastc = cyc - 1;
        for (int k = 0; k < NP + 2; k++) step(0, 0, 77, 20, 12, 4'b0101);
        if (got_cyc.size() == 1) begin
            check("mux_sad_const", got_sad[0], 8);
            check("mux_idx_const", got_idx[0], 1);
            check("mux_latency", got_cyc[0] - lastc, NP);
        end
        verify("mux");

        // Valid gaps every other cycle: same answer, latency from last valid edge.
        for (int k = 0; k < 2 * BLK; k++) step(k % 2 == 0, k == 0, (k % 2 == 0) ? 10 : 99, 20, 12, 4'b0101);
        lastc = cyc - 2;
        for (int k = 0; k < NP + 2; k++) step(0, 0, 55, 20, 12, 4'b0101);
        if (got_cyc.size() == 1) begin
            check("gap_sad_const", got_sad[0], 8);
            check("gap_idx_const", got_idx[0], 1);
            check("gap_latency", got_cyc[0] - lastc, NP);
        end
        verify("gaps");

        // Absolute difference in both directions.
        for (int k = 0; k < BLK; k++)
            if (k % 2 == 0) step(1, k == 0, 200, 10, 10, NP'($urandom));
            else            step(1, 0, 10, 200, 200, NP'($urandom));
        idle_rnd(NP + 2);
        verify("abs");

        // Back-to-back blocks, then a restart two pixels in.
        for (int k = 0; k < 2 * BLK; k++) rnd_step(1, k % BLK == 0);
        idle_rnd(NP + 2);
        if (got_cyc.size() == 2) check("b2b_spacing", got_cyc[1] - got_cyc[0], BLK);
        verify("b2b");
        rnd_step(1, 1); rnd_step(1, 0);
        for (int k = 0; k < BLK; k++) rnd_step(1, k == 0);
        idle_rnd(NP + 2);
        verify("restart");

        // Reset at pixel 2 aborts the block; a clean block afterwards works.
        rnd_step(1, 1); rnd_step(1, 0);
        do_reset();
        idle_rnd(NP + 2);
        verify("aborted");
        for (int k = 0; k < BLK; k++) rnd_step(1, k == 0);
        idle_rnd(NP + 2);
        verify("post_reset");

        // Random gaps, stray valids outside a block, several blocks.
        for (int b = 0; b < 6; b++) begin
            int n;
            n = 0;
            rnd_step(1, 0);
            while (n < BLK) begin
                bit v;
                v = ($urandom_range(3) != 0);
                rnd_step(v, v && n == 0);
                if (v) n++;
            end
        end
        idle_rnd(NP + 2);
        verify("random");

        // Saturation on the ACC_W=8 instance: 256 x 255 must clamp, not wrap.
        for (int k = 0; k < SAT_BLK; k++) begin
            b_in_valid = 1; b_start = (k == 0); b_r = 8'd255; b_s1 = 8'd0; b_s2 = 8'd0; b_sel = '1;
            rnd_step(0, 0);
        end
        lastc = cyc - 1;
        b_in_valid = 0; b_start = 0;
        idle_rnd(NP + 2);
        check("sat_count", b_cnt, 1);
        check("sat_sad", b_got_sad, 255);
        check("sat_idx", b_got_idx, 0);
        check("sat_latency", b_got_cyc - lastc, NP);
        verify("idle_during_sat");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
